// File: rtl/cpu_step_controller.sv
// cpu_step_controller: debounced step/run buttons, run-rate divider
// and PC breakpoint, producing the picoMIPS cpu clock-enable pulse.

// Per-button front end: synchronizer, debounce, press detect.
module cpu_step_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic nRst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic          w_synced;

  assign w_synced = r_sync[1];
  assign o_press  = r_press;

  // Two-flop synchronizer, idles at the released (high) level.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_btn};
    end
  end

  // Level flips after CYCLES disagreeing cycles; 1->0 flip is a press.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (w_synced == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_cnt   <= '0;
        r_level <= w_synced;
        r_press <= r_level;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

module cpu_step_controller #(
  parameter int P_SIZE          = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RUN_DIV         = 5000000
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              stepBtn,
  input  logic              runBtn,
  input  logic              bpEnable,
  input  logic [P_SIZE-1:0] bpAddr,
  input  logic [P_SIZE-1:0] pc,
  output logic              cpuEn,
  output logic              running,
  output logic              halted,
  output logic [15:0]       stepCount
);

  localparam int DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);
  // Decision cycle: the registered pulse then lands on DIV_LAST.
  localparam logic [DW-1:0] DIV_PRE  = DW'(RUN_DIV - 2);

  typedef enum logic [1:0] {
    S_STOP,
    S_STEP,
    S_RUN,
    S_BREAK
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_div;
  logic          r_bypass;
  logic          r_cpuEn;
  logic          r_running;
  logic          r_halted;
  logic [15:0]   r_stepCount;
  logic          w_stepEv;
  logic          w_runEv;
  logic          w_bpHit;

  cpu_step_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk     (clk),
    .nRst    (nRst),
    .i_btn   (stepBtn),
    .o_press (w_stepEv)
  );

  cpu_step_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_run_db (
    .clk     (clk),
    .nRst    (nRst),
    .i_btn   (runBtn),
    .o_press (w_runEv)
  );

  assign w_bpHit = bpEnable && (pc == bpAddr) && !r_bypass;

  assign cpuEn     = r_cpuEn;
  assign running   = r_running;
  assign halted    = r_halted;
  assign stepCount = r_stepCount;

  // Execution FSM with registered enable/status outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state   <= S_STOP;
      r_div     <= '0;
      r_bypass  <= 1'b0;
      r_cpuEn   <= 1'b0;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_cpuEn <= 1'b0;
      unique case (r_state)
        S_STOP: begin
          if (w_runEv) begin
            r_state   <= S_RUN;
            r_div     <= '0;
            r_running <= 1'b1;
          end else if (w_stepEv) begin
            r_state <= S_STEP;
            r_cpuEn <= 1'b1;
          end
        end
        S_STEP: begin
          r_state <= S_STOP;
        end
        S_RUN: begin
          if (w_runEv) begin
            r_state   <= S_STOP;
            r_running <= 1'b0;
          end else begin
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + DW'(1);
            if (r_div == DIV_PRE) begin
              if (w_bpHit) begin
                r_state   <= S_BREAK;
                r_running <= 1'b0;
                r_halted  <= 1'b1;
              end else begin
                r_cpuEn  <= 1'b1;
                r_bypass <= 1'b0;
              end
            end
          end
        end
        S_BREAK: begin
          if (w_runEv) begin
            r_state   <= S_RUN;
            r_div     <= '0;
            r_bypass  <= 1'b1;
            r_running <= 1'b1;
            r_halted  <= 1'b0;
          end else if (w_stepEv) begin
            r_state  <= S_STEP;
            r_cpuEn  <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state <= S_STOP;
        end
      endcase
    end
  end

  // Count issued enable pulses, wrapping at 16 bits.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_stepCount <= 16'h0000;
    end else if (r_cpuEn) begin
      r_stepCount <= r_stepCount + 16'h0001;
    end
  end

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller.
// DEBOUNCE_CYCLES=4, RUN_DIV=8; PC model starts at 0x03.
module tb_cpu_step_controller;

  logic        clk;
  logic        nRst;
  logic        stepBtn;
  logic        runBtn;
  logic        bpEnable;
  logic [7:0]  bpAddr;
  logic [7:0]  pc;
  logic        cpuEn;
  logic        running;
  logic        halted;
  logic [15:0] stepCount;
  logic        pc_load;
  int          n_checks;
  int          n_fail;

  cpu_step_controller #(
    .P_SIZE          (8),
    .DEBOUNCE_CYCLES (4),
    .RUN_DIV         (8)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .stepBtn   (stepBtn),
    .runBtn    (runBtn),
    .bpEnable  (bpEnable),
    .bpAddr    (bpAddr),
    .pc        (pc),
    .cpuEn     (cpuEn),
    .running   (running),
    .halted    (halted),
    .stepCount (stepCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CPU PC: advances on each enabled clock edge.
  always @(posedge clk) begin
    if (pc_load) pc <= 8'h03;
    else if (cpuEn) pc <= pc + 8'h01;
  end

  task automatic do_reset();
    nRst     = 1'b0;
    stepBtn  = 1'b1;
    runBtn   = 1'b1;
    bpEnable = 1'b0;
    bpAddr   = 8'h00;
    pc_load  = 1'b1;
    repeat (2) @(negedge clk);
    nRst    = 1'b1;
    pc_load = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (cpuEn !== 1'b0) begin
      n_fail++; $display("FAIL reset_cpuEn got %b exp 0", cpuEn);
    end
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++; $display("FAIL reset_running got %b exp 0", running);
    end
    n_checks++;
    if (halted !== 1'b0) begin
      n_fail++; $display("FAIL reset_halted got %b exp 0", halted);
    end
    n_checks++;
    if (stepCount !== 16'h0000) begin
      n_fail++; $display("FAIL reset_count got %h exp 0000", stepCount);
    end
  endtask

  task automatic test_clean_step();
    int first;
    int cnt;
    do_reset();
    first = -1;
    cnt   = 0;
    for (int i = 0; i < 24; i++) begin
      if (cpuEn === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
      if (i == 0) stepBtn = 1'b0;
      if (i == 10) stepBtn = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (first != 7) begin
      n_fail++; $display("FAIL step_latency got %0d exp 7", first);
    end
    n_checks++;
    if (cnt != 1) begin
      n_fail++; $display("FAIL step_pulses got %0d exp 1", cnt);
    end
    n_checks++;
    if (stepCount !== 16'h0001) begin
      n_fail++; $display("FAIL step_count got %h exp 0001", stepCount);
    end
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++; $display("FAIL step_running got %b exp 0", running);
    end
  endtask

  task automatic test_bounce();
    int cnt;
    do_reset();
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (cpuEn === 1'b1) cnt++;
      if (i < 20) stepBtn = ((i % 4) == 3);
      else stepBtn = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (cnt != 0) begin
      n_fail++; $display("FAIL bounce_pulses got %0d exp 0", cnt);
    end
    n_checks++;
    if (stepCount !== 16'h0000) begin
      n_fail++; $display("FAIL bounce_count got %h exp 0000", stepCount);
    end
  endtask

  task automatic test_run_stop();
    logic exp_en;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      exp_en = (i == 14) || (i == 22) || (i == 30);
      n_checks++;
      if (cpuEn !== exp_en) begin
        n_fail++;
        $display("FAIL run_en cyc %0d got %b exp %b", i, cpuEn, exp_en);
      end
      if (i == 6 || i == 38 || i == 59) begin
        n_checks++;
        if (running !== 1'b0) begin
          n_fail++; $display("FAIL run_off cyc %0d got %b exp 0", i, running);
        end
      end
      if (i == 7 || i == 37) begin
        n_checks++;
        if (running !== 1'b1) begin
          n_fail++; $display("FAIL run_on cyc %0d got %b exp 1", i, running);
        end
      end
      if (i == 0) runBtn = 1'b0;
      if (i == 10) runBtn = 1'b1;
      if (i == 16) stepBtn = 1'b0;
      if (i == 26) stepBtn = 1'b1;
      if (i == 31) runBtn = 1'b0;
      if (i == 41) runBtn = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (stepCount !== 16'd3) begin
      n_fail++; $display("FAIL run_count got %0d exp 3", stepCount);
    end
  endtask

  task automatic test_breakpoint();
    logic exp_en;
    logic exp_h;
    logic exp_r;
    do_reset();
    bpEnable = 1'b1;
    bpAddr   = 8'h05;
    for (int i = 0; i < 150; i++) begin
      exp_en = i inside {14, 22, 86, 94, 102, 122};
      exp_h  = (i >= 30 && i <= 78) || (i >= 110 && i <= 121);
      exp_r  = (i >= 7 && i <= 29) || (i >= 79 && i <= 109);
      n_checks++;
      if (cpuEn !== exp_en) begin
        n_fail++;
        $display("FAIL bp_en cyc %0d got %b exp %b", i, cpuEn, exp_en);
      end
      n_checks++;
      if (halted !== exp_h) begin
        n_fail++;
        $display("FAIL bp_halted cyc %0d got %b exp %b", i, halted, exp_h);
      end
      n_checks++;
      if (running !== exp_r) begin
        n_fail++;
        $display("FAIL bp_running cyc %0d got %b exp %b", i, running, exp_r);
      end
      if (i == 30) begin
        n_checks++;
        if (pc !== 8'h05) begin
          n_fail++; $display("FAIL bp_pc_halt got %h exp 05", pc);
        end
      end
      if (i == 0) runBtn = 1'b0;
      if (i == 10) runBtn = 1'b1;
      if (i == 40) bpEnable = 1'b0;
      if (i == 65) bpEnable = 1'b1;
      if (i == 72) runBtn = 1'b0;
      if (i == 82) runBtn = 1'b1;
      if (i == 88) bpAddr = 8'h08;
      if (i == 115) stepBtn = 1'b0;
      if (i == 125) stepBtn = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (pc !== 8'h09) begin
      n_fail++; $display("FAIL bp_pc_end got %h exp 09", pc);
    end
    n_checks++;
    if (stepCount !== 16'd6) begin
      n_fail++; $display("FAIL bp_count got %0d exp 6", stepCount);
    end
  endtask

  task automatic test_simultaneous();
    logic exp_en;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      exp_en = (i == 14) || (i == 22);
      n_checks++;
      if (cpuEn !== exp_en) begin
        n_fail++;
        $display("FAIL simul_en cyc %0d got %b exp %b", i, cpuEn, exp_en);
      end
      if (i == 7) begin
        n_checks++;
        if (running !== 1'b1) begin
          n_fail++; $display("FAIL simul_running got %b exp 1", running);
        end
      end
      if (i == 0) begin
        stepBtn = 1'b0;
        runBtn  = 1'b0;
      end
      if (i == 10) begin
        stepBtn = 1'b1;
        runBtn  = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_run();
    int cnt;
    do_reset();
    for (int i = 0; i < 22; i++) begin
      if (i == 0) runBtn = 1'b0;
      if (i == 10) runBtn = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (cpuEn !== 1'b1) begin
      n_fail++; $display("FAIL midrun_pulse got %b exp 1", cpuEn);
    end
    nRst = 1'b0;
    #1;
    n_checks++;
    if (cpuEn !== 1'b0) begin
      n_fail++; $display("FAIL midrun_cpuEn got %b exp 0", cpuEn);
    end
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++; $display("FAIL midrun_running got %b exp 0", running);
    end
    n_checks++;
    if (stepCount !== 16'h0000) begin
      n_fail++; $display("FAIL midrun_count got %h exp 0000", stepCount);
    end
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    cnt  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpuEn === 1'b1) cnt++;
    end
    n_checks++;
    if (cnt != 0) begin
      n_fail++; $display("FAIL midrun_after got %0d pulses exp 0", cnt);
    end
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++; $display("FAIL midrun_after_run got %b exp 0", running);
    end
  endtask

  task automatic test_wrap();
    int cnt;
    do_reset();
    force dut.r_stepCount = 16'hFFFE;
    #1;
    release dut.r_stepCount;
    for (int p = 0; p < 2; p++) begin
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (cpuEn === 1'b1) cnt++;
        if (i == 0) stepBtn = 1'b0;
        if (i == 10) stepBtn = 1'b1;
      end
      n_checks++;
      if (cnt != 1) begin
        n_fail++; $display("FAIL wrap_pulses p%0d got %0d exp 1", p, cnt);
      end
      n_checks++;
      if (stepCount !== ((p == 0) ? 16'hFFFF : 16'h0000)) begin
        n_fail++;
        $display("FAIL wrap_count p%0d got %h exp %h", p, stepCount,
                 (p == 0) ? 16'hFFFF : 16'h0000);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_clean_step();
    test_bounce();
    test_run_stop();
    test_breakpoint();
    test_simultaneous();
    test_reset_mid_run();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
